fetch_seq: RTL
==============

Name: fetch_seq

Overview:
Instruction-fetch sequencer for the 8-bit CPU. It owns the program counter and drives the address of the 256x8 combinational-read instruction ROM. It assembles one- or two-byte instructions (opcode plus optional immediate) and presents them to decode over a valid/ready handshake. It also handles branch redirects, run/stall gating and the HALT opcode. It sits between the instruction ROM and the decode/execute stage in the CPU top level.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
HALT_OP, 8'h3F, opcode that stops fetching; it is consumed and never presented to decode.
IMM_PREFIX, 2'b11, opcode[7:6] value marking a two-byte instruction (immediate byte follows).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_addr  out  8  ROM address; always equals the PC register.
imem_instr  in  8  ROM read data, combinational from imem_addr.
run_en  in  1  fetch enable; low stalls fetching.
redirect  in  1  taken branch/jump; one-cycle pulse.
redirect_pc  in  8  target address, sampled when redirect=1.
out_valid  out  1  instruction held for decode.
out_ready  in  1  decode accepts the instruction.
out_opcode  out  8  opcode byte.
out_imm  out  8  immediate byte; 8'h00 when out_has_imm=0.
out_has_imm  out  1  instruction is two-byte.
out_pc  out  8  address of the opcode byte.
halted  out  1  HALT executed; fetch stopped.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_OP, out_valid=0, out_opcode/out_imm/out_pc=0, out_has_imm=0, halted=0. Deassertion is synchronised externally; the first fetch happens on the first clk edge with rst_n=1.
- Reset mid-operation aborts any partial instruction immediately; no output glitches to valid=1.
- All state is in registers. imem_addr=pc is the only combinational output.
- S_OP, run_en=1:
  - Capture imem_instr into out_opcode and pc into out_pc; pc<=pc+1.
  - If opcode==HALT_OP: go to S_HALT, halted=1.
  - Else if opcode[7:6]==IMM_PREFIX: go to S_IMM.
  - Else: out_has_imm=0, out_imm=0, go to S_OUT.
- S_IMM, run_en=1: out_imm<=imem_instr; out_has_imm<=1; pc<=pc+1; go to S_OUT.
- S_OP/S_IMM with run_en=0: hold everything (pc, state, captured bytes).
- S_OUT: out_valid=1. Outputs stay stable until out_ready=1 at a clock edge; then out_valid=0 the next cycle and state goes to S_OP. run_en is ignored in S_OUT.
- S_HALT: out_valid=0, halted=1, pc holds the address after HALT. Exited only by redirect or reset.
- Latency: a one-byte instruction is valid 1 cycle after fetch; a two-byte instruction after 2 cycles. Minimum 2 cycles per one-byte instruction and 3 per two-byte instruction (S_OUT to S_OP turnaround).
- redirect=1 has highest priority in every state:
  - pc<=redirect_pc, state<=S_OP, halted<=0, out_valid<=0 next cycle.
  - Any partially fetched or pending instruction is discarded.
  - Redirect together with an out_ready handshake in S_OUT: the handshake counts as completed, and the redirect is applied as above.
  - Redirect during S_IMM: the immediate is not captured.
- Wrap-around: pc increments modulo 256 (8'hFF+1=8'h00). A two-byte opcode at 8'hFF takes its immediate from 8'h00.
- HALT_OP with opcode[7:6]==IMM_PREFIX is not permitted by the parameter choice; HALT takes priority.

Decomposition:
- Shared package (cpu_pkg): fetch state encoding (S_OP, S_IMM, S_OUT, S_HALT as 2-bit localparams), HALT_OP and IMM_PREFIX defaults, the PC width constant (8).
- No sub-module. fetch_seq is instantiated beside the instruction ROM in the CPU top, with imem_addr/imem_instr wired to the ROM address/data.

Test Plan:
- ROM {00:12, 01:C5, 02:AA, 03:3F}, run_en=1, out_ready=1 -> handshakes (opc 12, has_imm 0, pc 00), (C5, imm AA, pc 01); then halted=1 with pc=04 and no further out_valid.
- Same ROM, out_ready held 0 for 5 cycles after the first valid -> out_valid and outputs stable for 5 cycles, pc stays 01, then proceeds normally.
- In S_IMM after opcode C5 at 01, pulse redirect with redirect_pc=40 -> no instruction presented for pc 01; next valid has out_pc=40.
- PC preset via redirect to FF, ROM[FF]=C0, ROM[00]=77 -> output opc C0, imm 77, out_pc FF; pc wraps to 01.
- Halted, then redirect_pc=10 -> halted=0 next cycle, fetch resumes at 10. run_en=0 for 3 cycles in S_OP -> pc and state frozen, no valid.
- Assert rst_n=0 while in S_OUT -> out_valid=0 immediately (asynchronous), pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU.
// Contents:
//   - PC_W        : program counter / instruction address width.
//   - HALT_OP_DEF : default HALT opcode.
//   - IMM_PREFIX_DEF : default opcode[7:6] value marking a two-byte instruction.
//   - fetch_state_t : fetch sequencer state encoding.
package cpu_pkg;

  localparam int unsigned PC_W = 8;

  localparam logic [7:0] HALT_OP_DEF    = 8'h3F;
  localparam logic [1:0] IMM_PREFIX_DEF = 2'b11;

  // S_OP  : fetch opcode byte
  // S_IMM : fetch immediate byte of a two-byte instruction
  // S_OUT : instruction held for decode until accepted
  // S_HALT: HALT consumed, fetch stopped until redirect
  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_IMM  = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer.
// Owns the PC, addresses the combinational-read instruction ROM, assembles
// one- or two-byte instructions and hands them to decode over valid/ready.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   imem_addr [7:0]     : ROM address, always equal to the PC register
//   imem_instr [7:0]    : ROM read data for imem_addr
//   run_en              : fetch enable; low stalls S_OP/S_IMM
//   redirect            : taken branch/jump pulse, highest priority
//   redirect_pc [7:0]   : branch target, sampled with redirect
//   out_valid/out_ready : decode handshake
//   out_opcode [7:0]    : opcode byte
//   out_imm [7:0]       : immediate byte, 0 for one-byte instructions
//   out_has_imm         : instruction is two bytes
//   out_pc [7:0]        : address of the opcode byte
//   halted              : HALT executed, fetch stopped
module fetch_seq
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
  parameter logic [7:0]      HALT_OP    = HALT_OP_DEF,
  parameter logic [1:0]      IMM_PREFIX = IMM_PREFIX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_instr,
  input  logic            run_en,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_opcode,
  output logic [7:0]      out_imm,
  output logic            out_has_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            halted
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;

  assign imem_addr = pc;

  // NOTE: every register, outputs included, is reset here so an asynchronous
  // reset drops out_valid at once; sequential state uses <= only so all
  // updates in a cycle see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OP;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_opcode  <= 8'h00;
      out_imm     <= 8'h00;
      out_has_imm <= 1'b0;
      out_pc      <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      // Discards any partial or pending instruction; a simultaneous
      // handshake in S_OUT is simply treated as completed.
      pc        <= redirect_pc;
      state     <= S_OP;
      halted    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_OP: begin
          if (run_en) begin
            out_opcode  <= imem_instr;
            out_pc      <= pc;
            pc          <= pc + 1'b1;
            // Clear the immediate up front so out_imm is 0 whenever
            // out_has_imm is 0, including while the immediate is pending.
            out_imm     <= 8'h00;
            out_has_imm <= 1'b0;
            if (imem_instr == HALT_OP) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (imem_instr[7:6] == IMM_PREFIX) begin
              state <= S_IMM;
            end else begin
              state     <= S_OUT;
              out_valid <= 1'b1;
            end
          end
        end
        S_IMM: begin
          if (run_en) begin
            out_imm     <= imem_instr;
            out_has_imm <= 1'b1;
            pc          <= pc + 1'b1;
            state       <= S_OUT;
            out_valid   <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_OP;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule
